gps_multi_sat_gen: RTL

//  Parametrised multi-channel GPS L1 C/A baseband signal generator (successor to the single-channel core).
//  Per channel: C/A Gold code with programmable start code phase (seek), carrier NCO with signed Doppler, BPSK by data bit.

---
 rtl/gps_gen_pkg.sv | 59 +++++
 rtl/gps_gen_chan.sv | 107 ++++++++++
 rtl/gps_multi_sat_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gps_gen_pkg.sv
// Shared definitions for the multi-channel GPS L1 C/A generator:
// Gold code seeds, G2 phase-selector tap table, FSM states and noise LFSR constants.
package gps_gen_pkg;

  localparam logic [9:0]  GOLD_INIT  = 10'h3FF;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY  = 16'hB400;
  localparam logic [9:0]  CHIP_LAST  = 10'd1022;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_RUN
  } genState_t;

  // G2 output taps for PRN 1..32 (index = PRN-1), returned as zero-based
  // register positions {tapA, tapB}; stage k of the shift register lives at bit k-1.
  function automatic logic [7:0] g2TapPair(input logic [4:0] prnIdx);
    logic [3:0] a;
    logic [3:0] b;
    case (prnIdx)
      5'd0:  begin a = 4'd2; b = 4'd6;  end
      5'd1:  begin a = 4'd3; b = 4'd7;  end
      5'd2:  begin a = 4'd4; b = 4'd8;  end
      5'd3:  begin a = 4'd5; b = 4'd9;  end
      5'd4:  begin a = 4'd1; b = 4'd9;  end
      5'd5:  begin a = 4'd2; b = 4'd10; end
      5'd6:  begin a = 4'd1; b = 4'd8;  end
      5'd7:  begin a = 4'd2; b = 4'd9;  end
      5'd8:  begin a = 4'd3; b = 4'd10; end
      5'd9:  begin a = 4'd2; b = 4'd3;  end
      5'd10: begin a = 4'd3; b = 4'd4;  end
      5'd11: begin a = 4'd5; b = 4'd6;  end
      5'd12: begin a = 4'd6; b = 4'd7;  end
      5'd13: begin a = 4'd7; b = 4'd8;  end
      5'd14: begin a = 4'd8; b = 4'd9;  end
      5'd15: begin a = 4'd9; b = 4'd10; end
      5'd16: begin a = 4'd1; b = 4'd4;  end
      5'd17: begin a = 4'd2; b = 4'd5;  end
      5'd18: begin a = 4'd3; b = 4'd6;  end
      5'd19: begin a = 4'd4; b = 4'd7;  end
      5'd20: begin a = 4'd5; b = 4'd8;  end
      5'd21: begin a = 4'd6; b = 4'd9;  end
      5'd22: begin a = 4'd1; b = 4'd3;  end
      5'd23: begin a = 4'd4; b = 4'd6;  end
      5'd24: begin a = 4'd5; b = 4'd7;  end
      5'd25: begin a = 4'd6; b = 4'd8;  end
      5'd26: begin a = 4'd7; b = 4'd9;  end
      5'd27: begin a = 4'd8; b = 4'd10; end
      5'd28: begin a = 4'd1; b = 4'd6;  end
      5'd29: begin a = 4'd2; b = 4'd7;  end
      5'd30: begin a = 4'd3; b = 4'd8;  end
      default: begin a = 4'd4; b = 4'd9; end
    endcase
    return {a - 4'd1, b - 4'd1};
  endfunction

endpackage

// File: rtl/gps_gen_chan.sv
// One satellite channel: latched PRN/phase/enable, G1/G2 Gold code LFSRs with a
// seek counter, carrier NCO with signed Doppler, and the BPSK +/-1 output term.
module gps_gen_chan #(
  parameter int PH_W  = 10,
  parameter int DOP_W = 8,
  parameter int NCO_W = 16,
  parameter logic [NCO_W-1:0] IF_INC = NCO_W'(16'h4000)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [4:0]        i_prn,
  input  logic [PH_W-1:0]   i_caPhase,
  input  logic              i_seek,
  input  logic              i_chipStep,
  input  logic              i_ncoRun,
  input  logic [DOP_W-1:0]  i_doppler,
  input  logic              i_msg,
  output logic              o_seekDone,
  output logic signed [1:0] o_term
);
  import gps_gen_pkg::*;

  logic             r_en;
  logic [4:0]       r_prn;
  logic [PH_W-1:0]  r_caPhase;
  logic [9:0]       r_g1;
  logic [9:0]       r_g2;
  logic [PH_W-1:0]  r_seekCnt;
  logic [NCO_W-1:0] r_ncoPhase;

  logic [7:0]       w_taps;
  logic [3:0]       w_tapA;
  logic [3:0]       w_tapB;
  logic [9:0]       w_g1Next;
  logic [9:0]       w_g2Next;
  logic             w_seekStep;
  logic             w_codeStep;
  logic [NCO_W-1:0] w_ncoInc;
  logic             w_chip;
  logic             w_bit;

  assign w_taps   = g2TapPair(r_prn);
  assign w_tapA   = w_taps[7:4];
  assign w_tapB   = w_taps[3:0];
  // G1 = 1 + x^3 + x^10, G2 = 1 + x^2 + x^3 + x^6 + x^8 + x^9 + x^10
  assign w_g1Next = {r_g1[8:0], r_g1[2] ^ r_g1[9]};
  assign w_g2Next = {r_g2[8:0], r_g2[1] ^ r_g2[2] ^ r_g2[5] ^ r_g2[7] ^ r_g2[8] ^ r_g2[9]};

  assign w_seekStep = i_seek & r_en & (r_seekCnt < r_caPhase);
  assign w_codeStep = w_seekStep | (i_chipStep & r_en);
  assign w_ncoInc   = NCO_W'(signed'(i_doppler)) + IF_INC;

  assign o_seekDone = ~r_en | (r_seekCnt == r_caPhase);

  // Capture the channel configuration when a start is accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en      <= 1'b0;
      r_prn     <= '0;
      r_caPhase <= '0;
    end else if (i_load) begin
      r_en      <= i_en;
      r_prn     <= i_prn;
      r_caPhase <= i_caPhase;
    end
  end

  // Gold code registers and seek counter; held at the seed while idle
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_g1      <= GOLD_INIT;
      r_g2      <= GOLD_INIT;
      r_seekCnt <= '0;
    end else begin
      if (w_codeStep) begin
        r_g1 <= w_g1Next;
        r_g2 <= w_g2Next;
      end
      if (w_seekStep) begin
        r_seekCnt <= r_seekCnt + 1'b1;
      end
    end
  end

  // Carrier NCO advances only while running, otherwise parked at phase 0
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_ncoRun) begin
      r_ncoPhase <= '0;
    end else begin
      r_ncoPhase <= r_ncoPhase + w_ncoInc;
    end
  end

  // BPSK of chip, data bit and carrier sign into a +/-1 term (0 when disabled)
  always_comb begin
    w_chip = r_g1[9] ^ r_g2[w_tapA] ^ r_g2[w_tapB];
    w_bit  = w_chip ^ i_msg ^ r_ncoPhase[NCO_W-1];
    o_term = 2'sb00;
    if (r_en) begin
      o_term = w_bit ? 2'sb11 : 2'sb01;
    end
  end

endmodule

// File: rtl/gps_multi_sat_gen.sv
// Multi-channel GPS L1 C/A baseband generator: control FSM, chip divider/index,
// channel adder and registered signed output.
// Optional feature macro: GPS_GEN_NOISE_EN adds a +/-1 term from a 16-bit Galois LFSR.
module gps_multi_sat_gen #(
  parameter int N_CH     = 4,
  parameter int PH_W     = 10,
  parameter int DOP_W    = 8,
  parameter int NCO_W    = 16,
  parameter logic [NCO_W-1:0] IF_INC = NCO_W'(16'h4000),
  parameter int CHIP_DIV = 4,
  localparam int SUM_W   = $clog2(N_CH + 1) + 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    stop_in,
  input  logic [N_CH-1:0]         ch_en_in,
  input  logic [5*N_CH-1:0]       n_sat_in,
  input  logic [PH_W*N_CH-1:0]    ca_phase_in,
  input  logic [DOP_W*N_CH-1:0]   doppler_in,
  input  logic [N_CH-1:0]         msg_in,
  input  logic                    noise_off_in,
  output logic                    busy_out,
  output logic                    seek_done_out,
  output logic                    chip_strobe_out,
  output logic                    epoch_out,
  output logic signed [SUM_W-1:0] signal_out
);
  import gps_gen_pkg::*;

  localparam int DIV_W = $clog2(CHIP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHIP_DIV - 1);

  genState_t              r_state;
  genState_t              w_nextState;
  logic [DIV_W-1:0]       r_div;
  logic [9:0]             r_chipIdx;
  logic signed [SUM_W-1:0] r_sum;
  logic signed [SUM_W-1:0] w_sum;
  logic                   w_startAcc;
  logic                   w_chipStep;
  logic [N_CH-1:0]        w_chanDone;
  logic                   w_allDone;
  logic signed [1:0]      w_term [N_CH];

  assign w_allDone       = &w_chanDone;
  assign w_chipStep      = (r_state == ST_RUN) && (r_div == DIV_LAST);
  assign chip_strobe_out = w_chipStep;
  assign epoch_out       = w_chipStep && (r_chipIdx == CHIP_LAST);
  assign signal_out      = r_sum;

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state and status outputs; stop always wins over start
  always_comb begin
    w_nextState   = r_state;
    w_startAcc    = 1'b0;
    busy_out      = 1'b0;
    seek_done_out = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_in && !stop_in) begin
          w_startAcc  = 1'b1;
          w_nextState = ST_SEEK;
        end
      end
      ST_SEEK: begin
        busy_out = 1'b1;
        if (stop_in) begin
          w_nextState = ST_IDLE;
        end else if (w_allDone) begin
          seek_done_out = 1'b1;
          w_nextState   = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_out = 1'b1;
        if (stop_in) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Chip divider and chip index, both restart from 0 on every RUN entry
  always_ff @(posedge clk_in) begin
    if (rst_in || r_state != ST_RUN) begin
      r_div     <= '0;
      r_chipIdx <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div     <= '0;
      r_chipIdx <= (r_chipIdx == CHIP_LAST) ? 10'd0 : r_chipIdx + 10'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    gps_gen_chan #(
      .PH_W   (PH_W),
      .DOP_W  (DOP_W),
      .NCO_W  (NCO_W),
      .IF_INC (IF_INC)
    ) u_chan (
      .i_clk      (clk_in),
      .i_rst      (rst_in),
      .i_clr      (r_state == ST_IDLE),
      .i_load     (w_startAcc),
      .i_en       (ch_en_in[c]),
      .i_prn      (n_sat_in[c*5 +: 5]),
      .i_caPhase  (ca_phase_in[c*PH_W +: PH_W]),
      .i_seek     (r_state == ST_SEEK),
      .i_chipStep (w_chipStep),
      .i_ncoRun   (r_state == ST_RUN),
      .i_doppler  (doppler_in[c*DOP_W +: DOP_W]),
      .i_msg      (msg_in[c]),
      .o_seekDone (w_chanDone[c]),
      .o_term     (w_term[c])
    );
  end

`ifdef GPS_GEN_NOISE_EN
  logic [15:0] r_lfsr;

  // Noise LFSR steps once per RUN clock and keeps its state between runs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_state == ST_RUN) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : 16'h0000);
    end
  end
`else
  logic w_unusedNoiseOff;
  assign w_unusedNoiseOff = noise_off_in;
`endif

  // Adder over all channel terms, plus the optional noise term
  always_comb begin
    w_sum = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_sum = w_sum + SUM_W'(w_term[c]);
    end
`ifdef GPS_GEN_NOISE_EN
    if (!noise_off_in) begin
      w_sum = r_lfsr[0] ? (w_sum - SUM_W'(1)) : (w_sum + SUM_W'(1));
    end
`endif
  end

  // Output register; forced to 0 unless RUN continues through this edge
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sum <= '0;
    end else if (r_state == ST_RUN && w_nextState == ST_RUN) begin
      r_sum <= w_sum;
    end else begin
      r_sum <= '0;
    end
  end

endmodule
